// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, FSM states and load formatting for the 4-way data cache.
package cache_pkg;
  localparam int ADR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int WORD_OFFSET = 2;
  localparam int INDEX_WIDTH = 8;
  localparam int TAG_WIDTH = ADR_WIDTH - INDEX_WIDTH - WORD_OFFSET - 2;
  localparam int WAYS = 4;
  localparam int SETS = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << WORD_OFFSET;
  localparam int IDX_LSB = WORD_OFFSET + 2;
  localparam int TAG_LSB = IDX_LSB + INDEX_WIDTH;
  localparam int PLRU_HALF = 0;
  localparam int PLRU_LO = 1;
  localparam int PLRU_HI = 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, RELEASE} state_t;
  // Big-endian byte pick: byte 0 lives in bits [31:24]; lb takes priority over lbu.
  function automatic logic [DATA_WIDTH-1:0] load_fmt(input logic [DATA_WIDTH-1:0] w, input logic [1:0] b,
                                                     input logic lb, input logic lbu);
    logic [7:0] by;
    by = w[{~b, 3'b000} +: 8];
    return lb ? {{24{by[7]}}, by} : lbu ? {24'h0, by} : w;
  endfunction
endpackage

// File: rtl/cache_controller_if.sv
// cache_controller_if: CPU load/store bus and read-only refill bus between the cache and its neighbours.
interface cpu_bus_if;
  import cache_pkg::*;
  logic req_cpu2cc;
  logic [ADR_WIDTH-1:0] adr_cpu2cc;
  logic [DATA_WIDTH-1:0] dat_cpu2cc;
  logic rdwr_cpu2cc;
  logic lb_cpu2cc;
  logic lbu_cpu2cc;
  logic ack_cc2cpu;
  logic [DATA_WIDTH-1:0] dat_cc2cpu;
  modport master(output req_cpu2cc, adr_cpu2cc, dat_cpu2cc, rdwr_cpu2cc, lb_cpu2cc, lbu_cpu2cc,
                 input ack_cc2cpu, dat_cc2cpu);
  modport slave(input req_cpu2cc, adr_cpu2cc, dat_cpu2cc, rdwr_cpu2cc, lb_cpu2cc, lbu_cpu2cc,
                output ack_cc2cpu, dat_cc2cpu);
endinterface

interface mem_bus_if;
  import cache_pkg::*;
  logic req_cc2mem;
  logic [ADR_WIDTH-1:0] adr_cc2mem;
  logic ack_mem2cc;
  logic [DATA_WIDTH-1:0] dat_mem2cc;
  modport master(output req_cc2mem, adr_cc2mem, input ack_mem2cc, dat_mem2cc);
  modport slave(input req_cc2mem, adr_cc2mem, output ack_mem2cc, dat_mem2cc);
endinterface

// File: rtl/cache_plru.sv
// cache_plru: per-set 3-bit tree pseudo-LRU; bits point at the victim, accesses point them away.
module cache_plru
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] idx,
  output logic [1:0]             victim,
  input  logic                   upd,
  input  logic [INDEX_WIDTH-1:0] upd_idx,
  input  logic [1:0]             upd_way
);
  logic [2:0] tree [SETS];
  logic [2:0] t;
  assign t = tree[idx];
  assign victim = t[PLRU_HALF] ? {1'b1, t[PLRU_HI]} : {1'b0, t[PLRU_LO]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SETS; i++) tree[i] <= '0;
    end else if (upd) begin
      tree[upd_idx][PLRU_HALF] <= ~upd_way[1];
      if (upd_way[1]) tree[upd_idx][PLRU_HI] <= ~upd_way[0];
      else tree[upd_idx][PLRU_LO] <= ~upd_way[0];
    end
  end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: 4-way set-associative read/write-allocate data cache with a read-only word-wide refill port.
module cache_controller
  import cache_pkg::*;
(
  input logic        clk,
  input logic        rst,
  cpu_bus_if.slave   cpu,
  mem_bus_if.master  mem
);
  logic [TAG_WIDTH-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem [SETS][WAYS][WORDS];
  logic [WAYS-1:0]       valid    [SETS];
  logic [TAG_WIDTH-1:0]  rd_tag   [WAYS];
  logic [DATA_WIDTH-1:0] rd_word  [WAYS];
  state_t state, nxt;
  logic [ADR_WIDTH-1:0] adr_q, adrm_q;
  logic [DATA_WIDTH-1:0] dat_q, resp_word, dat_out, dat_d, we_dat;
  logic wr_q, lb_q, lbu_q, ack_q, ack_d, req_q;
  logic [1:0] cnt, way_q, hit_way, free_way, plru_victim, victim_sel, plru_way, we_way, we_word;
  logic hit, take, miss, fill_done, plru_upd, we;
  logic [INDEX_WIDTH-1:0] idx_q, in_idx;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [1:0] word_q, byte_q, in_word;
  assign idx_q = adr_q[TAG_LSB-1:IDX_LSB];
  assign tag_q = adr_q[ADR_WIDTH-1:TAG_LSB];
  assign word_q = adr_q[IDX_LSB-1:2];
  assign byte_q = adr_q[1:0];
  assign in_idx = cpu.adr_cpu2cc[TAG_LSB-1:IDX_LSB];
  assign in_word = cpu.adr_cpu2cc[IDX_LSB-1:2];
  assign take = state == IDLE && cpu.req_cpu2cc;
  assign victim_sel = &valid[idx_q] ? plru_victim : free_way;
  assign cpu.ack_cc2cpu = ack_q;
  assign cpu.dat_cc2cpu = dat_out;
  assign mem.req_cc2mem = req_q;
  assign mem.adr_cc2mem = adrm_q;
  cache_plru u_plru (
    .clk(clk), .rst(rst), .idx(idx_q), .victim(plru_victim),
    .upd(plru_upd), .upd_idx(idx_q), .upd_way(plru_way)
  );
  // Lowest-numbered invalid way wins, so scan downward and let the last match stick.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx_q][w] && rd_tag[w] == tag_q) begin
        hit = 1'b1;
        hit_way = 2'(w);
      end
      if (!valid[idx_q][w]) free_way = 2'(w);
    end
  end
  always_comb begin
    nxt = state;
    ack_d = 1'b0;
    dat_d = '0;
    miss = 1'b0;
    fill_done = 1'b0;
    plru_upd = 1'b0;
    plru_way = hit_way;
    we = 1'b0;
    we_way = hit_way;
    we_word = word_q;
    we_dat = dat_q;
    case (state)
      IDLE: nxt = cpu.req_cpu2cc ? LOOKUP : IDLE;
      LOOKUP: begin
        if (hit) begin
          ack_d = 1'b1;
          dat_d = wr_q ? '0 : load_fmt(rd_word[hit_way], byte_q, lb_q, lbu_q);
          plru_upd = 1'b1;
          we = wr_q;
          nxt = RELEASE;
        end else begin
          miss = 1'b1;
          nxt = REFILL;
        end
      end
      REFILL: begin
        if (mem.ack_mem2cc) begin
          we = 1'b1;
          we_way = way_q;
          we_word = cnt;
          we_dat = mem.dat_mem2cc;
          if (cnt == 2'd3) begin
            fill_done = 1'b1;
            plru_upd = 1'b1;
            plru_way = way_q;
            nxt = RESPOND;
          end
        end
      end
      RESPOND: begin
        ack_d = 1'b1;
        dat_d = wr_q ? '0 : load_fmt(resp_word, byte_q, lb_q, lbu_q);
        we = wr_q;
        we_way = way_q;
        nxt = RELEASE;
      end
      RELEASE: nxt = cpu.req_cpu2cc ? RELEASE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (take) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_tag[w] <= tag_mem[in_idx][w];
        rd_word[w] <= data_mem[in_idx][w][in_word];
      end
    end
    if (we) data_mem[idx_q][we_way][we_word] <= we_dat;
    if (fill_done) tag_mem[idx_q][way_q] <= tag_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ack_q <= 1'b0;
      dat_out <= '0;
      req_q <= 1'b0;
      adrm_q <= '0;
      cnt <= '0;
      way_q <= '0;
      resp_word <= '0;
      adr_q <= '0;
      dat_q <= '0;
      wr_q <= 1'b0;
      lb_q <= 1'b0;
      lbu_q <= 1'b0;
      for (int i = 0; i < SETS; i++) valid[i] <= '0;
    end else begin
      state <= nxt;
      ack_q <= ack_d;
      dat_out <= dat_d;
      if (take) begin
        adr_q <= cpu.adr_cpu2cc;
        dat_q <= cpu.dat_cpu2cc;
        wr_q <= cpu.rdwr_cpu2cc;
        lb_q <= cpu.lb_cpu2cc;
        lbu_q <= cpu.lbu_cpu2cc;
      end
      // The victim is invalidated up front so an aborted refill never leaves a half-written live line.
      if (miss) begin
        req_q <= 1'b1;
        adrm_q <= {adr_q[ADR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
        way_q <= victim_sel;
        cnt <= '0;
        valid[idx_q][victim_sel] <= 1'b0;
      end
      if (state == REFILL && mem.ack_mem2cc) begin
        cnt <= cnt + 2'd1;
        if (cnt == word_q) resp_word <= mem.dat_mem2cc;
      end
      if (fill_done) begin
        req_q <= 1'b0;
        valid[idx_q][way_q] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized and directed accesses checked against a timestamp-based cache model.
module tb_cache_controller;
  import cache_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  cpu_bus_if cpu();
  mem_bus_if mem();
  cache_controller dut(.clk(clk), .rst(rst), .cpu(cpu), .mem(mem));
  int n_checks = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  bit          m_v   [256][4];
  logic [19:0] m_tag [256][4];
  logic [31:0] m_d   [256][4][4];
  int          m_ts  [256][4];
  int          now = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a[31:4] == 28'hFF07BD0 ? 32'hFFFF_FFFF : (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction
  function automatic void model_reset();
    for (int s = 0; s < 256; s++)
      for (int w = 0; w < 4; w++) begin
        m_v[s][w] = 0;
        m_ts[s][w] = 0;
      end
  endfunction
  // Tree PLRU == "avoid the half holding the most recent access, then the more recent of that pair".
  function automatic void model(input logic [31:0] a, input bit wr, input logic [31:0] wd, input bit lb,
                                input bit lbu, output bit miss, output logic [31:0] rd);
    int s, h, mru, half;
    logic [31:0] w;
    logic [7:0] by;
    s = int'(a[11:4]);
    h = -1;
    for (int i = 0; i < 4; i++) if (m_v[s][i] && m_tag[s][i] == a[31:12]) h = i;
    miss = h < 0;
    if (miss) begin
      for (int i = 3; i >= 0; i--) if (!m_v[s][i]) h = i;
      if (h < 0) begin
        mru = 0;
        for (int i = 1; i < 4; i++) if (m_ts[s][i] > m_ts[s][mru]) mru = i;
        half = mru < 2 ? 2 : 0;
        h = m_ts[s][half] <= m_ts[s][half + 1] ? half : half + 1;
      end
      m_v[s][h] = 1;
      m_tag[s][h] = a[31:12];
      for (int k = 0; k < 4; k++) m_d[s][h][k] = mem_word({a[31:4], 4'h0} + 32'(4 * k));
    end
    now++;
    m_ts[s][h] = now;
    if (wr) begin
      m_d[s][h][a[3:2]] = wd;
      rd = 0;
    end else begin
      w = m_d[s][h][a[3:2]];
      by = 8'(w >> (8 * (3 - int'(a[1:0]))));
      rd = lb ? {{24{by[7]}}, by} : lbu ? {24'h0, by} : w;
    end
  endfunction
  int mcnt = 0;
  always @(negedge clk) begin
    if (!mem.req_cc2mem) begin
      mcnt = 0;
      mem.ack_mem2cc = $urandom_range(0, 7) == 0;
      mem.dat_mem2cc = $urandom;
    end else if (mcnt < 4 && $urandom_range(0, 3) != 0) begin
      mem.ack_mem2cc = 1'b1;
      mem.dat_mem2cc = mem_word(mem.adr_cc2mem + 32'(4 * mcnt));
      mcnt++;
    end else begin
      mem.ack_mem2cc = 1'b0;
      mem.dat_mem2cc = $urandom;
    end
  end
  task automatic access(input logic [31:0] a, input bit wr, input logic [31:0] wd, input bit lb,
                        input bit lbu, input int hold);
    bit em, miss;
    logic [31:0] er;
    int cyc, acks;
    model(a, wr, wd, lb, lbu, em, er);
    miss = 0;
    cyc = 0;
    acks = 0;
    @(negedge clk);
    cpu.req_cpu2cc = 1'b1;
    cpu.adr_cpu2cc = a;
    cpu.dat_cpu2cc = wd;
    cpu.rdwr_cpu2cc = wr;
    cpu.lb_cpu2cc = lb;
    cpu.lbu_cpu2cc = lbu;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem.req_cc2mem && !miss) begin
        check("refill_adr", mem.adr_cc2mem, {a[31:4], 4'h0});
        miss = 1;
      end
    end while (!cpu.ack_cc2cpu && cyc < 200);
    check("ack", 32'(cpu.ack_cc2cpu), 1);
    check(wr ? "store_dat" : "load_dat", cpu.dat_cc2cpu, er);
    check("miss", 32'(miss), 32'(em));
    if (!em) check("hit_latency", 32'(cyc), 2);
    repeat (hold + 1) begin
      @(posedge clk);
      #1;
      acks += int'(cpu.ack_cc2cpu);
    end
    @(negedge clk);
    cpu.req_cpu2cc = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      acks += int'(cpu.ack_cc2cpu);
    end
    check("single_ack", 32'(acks), 0);
  endtask
  logic [19:0] tags [6] = '{20'hFF07B, 20'hA5552, 20'hD500A, 20'hFFFFF, 20'hAFD52, 20'h12345};
  initial begin
    int cyc;
    cpu.req_cpu2cc = 1'b0;
    cpu.adr_cpu2cc = '0;
    cpu.dat_cpu2cc = '0;
    cpu.rdwr_cpu2cc = 1'b0;
    cpu.lb_cpu2cc = 1'b0;
    cpu.lbu_cpu2cc = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(cpu.ack_cc2cpu), 0);
    check("rst_dat", cpu.dat_cc2cpu, 0);
    check("rst_req", 32'(mem.req_cc2mem), 0);
    check("rst_adr", mem.adr_cc2mem, 0);
    @(negedge clk);
    rst = 1'b1;
    access(32'hFF07BD08, 0, 0, 0, 0, 0);
    access(32'hA5552D0C, 0, 0, 0, 0, 0);
    access(32'hD500AD00, 0, 0, 0, 0, 0);
    access(32'hFFFFFD08, 0, 0, 0, 0, 0);
    access(32'hFF07BD00, 0, 0, 0, 0, 0);
    access(32'hA5552D08, 1, 32'hAA8AAAA4, 0, 0, 0);
    access(32'hFFFFFD08, 1, 32'h1234ABCD, 0, 0, 0);
    access(32'hAFD52D08, 0, 0, 0, 0, 0);
    access(32'hA5552D08, 0, 0, 0, 0, 0);
    access(32'hD500AD00, 0, 0, 0, 0, 0);
    access(32'hFF07BD04, 0, 0, 0, 0, 0);
    access(32'hA5552D0C, 1, 32'hAAEBAAB4, 0, 0, 0);
    access(32'hA5552D0C, 0, 0, 0, 1, 0);
    access(32'hA5552D0C, 0, 0, 1, 0, 0);
    access(32'hA5552D0D, 0, 0, 0, 1, 0);
    access(32'hA5552D0D, 0, 0, 1, 0, 0);
    access(32'hA5552D0E, 0, 0, 1, 1, 0);
    access(32'hA5552D0F, 0, 0, 0, 0, 3);
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      bit wr, lb, lbu;
      a = {tags[$urandom_range(0, 5)], $urandom_range(0, 1) != 0 ? 8'hD0 : 8'h01, 4'($urandom)};
      wr = $urandom_range(0, 3) == 0;
      lb = !wr && $urandom_range(0, 2) == 0;
      lbu = !wr && $urandom_range(0, 2) == 0;
      access(a, wr, $urandom, lb, lbu, $urandom_range(0, 2));
    end
    @(negedge clk);
    cpu.req_cpu2cc = 1'b1;
    cpu.adr_cpu2cc = 32'h12345670;
    cpu.rdwr_cpu2cc = 1'b0;
    cpu.lb_cpu2cc = 1'b0;
    cpu.lbu_cpu2cc = 1'b0;
    cyc = 0;
    while (!mem.req_cc2mem && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_refill_started", 32'(mem.req_cc2mem), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_ack", 32'(cpu.ack_cc2cpu), 0);
    check("abort_dat", cpu.dat_cc2cpu, 0);
    check("abort_req", 32'(mem.req_cc2mem), 0);
    check("abort_adr", mem.adr_cc2mem, 0);
    model_reset();
    cpu.req_cpu2cc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    access(32'h12345670, 0, 0, 0, 0, 0);
    access(32'hA5552D0C, 0, 0, 0, 0, 0);
    access(32'h12345674, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
